plate_region_locate: RTL
========================

Name: plate_region_locate

Overview:
- Scans the binarized camera stream and measures the bounding box of the foreground object, such as a plate or character block.
- Measurement is confined to a fixed search window, once per frame.
- Produces the edge_left / edge_right / edge_up / edge_dowm coordinates that the LCD overlay stage draws as red box lines.
- Sits upstream of the overlay, on the same video timing and x/y counters.

Parameters:
- WIN_LEFT, 50, leftmost x column scanned (inclusive).
- WIN_RIGHT, 430, rightmost x column scanned (inclusive).
- WIN_UP, 70, top y row scanned (inclusive).
- WIN_DOWN, 200, bottom y row scanned (inclusive).
- ROW_TH, 8, minimum number of foreground pixels for a row to qualify.
- MIN_ROWS, 4, minimum number of qualified rows for the frame result to be valid.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous reset, active-high
- x  input  12  current pixel column
- y  input  12  current pixel row
- i_hs  input  1  hsync (unused internally; reserved)
- i_vs  input  1  vsync, active-high; its rising edge marks frame end
- i_de  input  1  data enable
- i_bin  input  1  binarized pixel, 1 = foreground
- edge_left  output  12  left box edge, x
- edge_right  output  12  right box edge, x
- edge_up  output  12  top box edge, y
- edge_dowm  output  12  bottom box edge, y
- region_valid  output  1  last closed frame contained a valid region
- frame_done  output  1  one-cycle pulse when the outputs update

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all four edges 0, region_valid 0, frame_done 0. All accumulators and registered de/vs are cleared.
- Reset mid-frame discards the partial frame. The first result after reset is produced at the next vs rising edge.
- in_win = i_de && WIN_LEFT<=x<=WIN_RIGHT && WIN_UP<=y<=WIN_DOWN.
- A pixel is a hit when in_win && i_bin.
- Row accumulators, updated on hits:
  - row_cnt increments, saturating at 4095.
  - row_min_x = min(row_min_x, x).
  - row_max_x = max(row_max_x, x).
  - row_y = y.
- Row close: the cycle with de_d=1 and i_de=0 (de_d is i_de registered one cycle).
  - If row_cnt >= ROW_TH, merge the row into the frame accumulators:
    - f_min_x = min(f_min_x, row_min_x)
    - f_max_x = max(f_max_x, row_max_x)
    - f_min_y = min(f_min_y, row_y)
    - f_max_y = max(f_max_y, row_y)
    - q_rows increments, saturating at 4095.
  - Row accumulators reset regardless: cnt=0, min=12'hFFF, max=0.
- Frame close: the cycle where i_vs=1 and vs_d=0 (vs_d is i_vs registered).
  - If a row close occurs in the same cycle, that row's merge is included in the frame result (forwarded, not lost).
  - If q_rows (including a same-cycle merge) >= MIN_ROWS:
    - edge_left=f_min_x, edge_right=f_max_x, edge_up=f_min_y, edge_dowm=f_max_y.
    - region_valid=1.
  - Otherwise: edges hold their previous values and region_valid=0.
  - frame_done=1 on the cycle after the close edge. Outputs change on that same cycle.
  - Frame accumulators reset: min=12'hFFF, max=0, q_rows=0.
- Latency: outputs are valid 1 clk after the vs rising edge is sampled.
- Pixels outside the window or with i_de=0 never affect any accumulator.
- A row that lies entirely outside the window closes with row_cnt=0 and is never merged.
- Comparisons are unsigned, 12-bit. No arithmetic beyond the increments.
- Register all outputs. No combinational path from inputs to outputs.

Test Plan:
- Solid rectangle: i_bin=1 for x 100..199, y 90..149, then vs rising → frame_done pulse next cycle; edges = 100/199/90/149; region_valid=1.
- Sparse rows: rows with 7 hits (below ROW_TH=8) at y 80..85 plus a rectangle x 150..170, y 120..130 → edge_up=120, edge_dowm=130 (the sparse rows are ignored).
- Empty frame after a valid one: no hits → region_valid=0; edges keep 100/199/90/149; frame_done still pulses.
- Out-of-window hits: a hit block at x 10..40 and y 210..230 plus a rectangle x 300..320, y 100..110 → edges = 300/320/100/110 only.
- Simultaneous close: last qualifying row at y=200 with i_de falling in the same cycle as i_vs rising → edge_dowm=200; q_rows includes that row.
- Reset mid-frame: rst pulsed at y=120 within rectangle rows 100..140 → all outputs 0. The next frame containing rows 125..140 only reports edge_up=125, with no carry-over from before the reset.

Source files
------------

// File: rtl/plate_region_locate.sv
// plate_region_locate: measures the bounding box of foreground pixels inside a fixed search window, once per frame.
module plate_region_locate #(
  parameter logic [11:0] WIN_LEFT  = 12'd50,
  parameter logic [11:0] WIN_RIGHT = 12'd430,
  parameter logic [11:0] WIN_UP    = 12'd70,
  parameter logic [11:0] WIN_DOWN  = 12'd200,
  parameter logic [11:0] ROW_TH    = 12'd8,
  parameter logic [11:0] MIN_ROWS  = 12'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic        i_bin,
  output logic [11:0] edge_left,
  output logic [11:0] edge_right,
  output logic [11:0] edge_up,
  output logic [11:0] edge_dowm,
  output logic        region_valid,
  output logic        frame_done
);
  logic        de_d, vs_d;
  logic [11:0] row_cnt, row_min_x, row_max_x, row_y;
  logic [11:0] f_min_x, f_max_x, f_min_y, f_max_y, q_rows;
  logic        hit, row_close, frame_close, row_ok, frame_ok;
  logic [11:0] m_min_x, m_max_x, m_min_y, m_max_y, m_q;
  logic        unused_hs;
  assign unused_hs = i_hs;
  // m_* are the frame accumulators with the closing row already merged, so a
  // row that closes on the vs edge still counts toward this frame.
  always_comb begin
    hit = i_de && i_bin && x >= WIN_LEFT && x <= WIN_RIGHT && y >= WIN_UP && y <= WIN_DOWN;
    row_close = de_d && !i_de;
    frame_close = i_vs && !vs_d;
    row_ok = row_close && row_cnt >= ROW_TH;
    m_min_x = (row_ok && row_min_x < f_min_x) ? row_min_x : f_min_x;
    m_max_x = (row_ok && row_max_x > f_max_x) ? row_max_x : f_max_x;
    m_min_y = (row_ok && row_y < f_min_y) ? row_y : f_min_y;
    m_max_y = (row_ok && row_y > f_max_y) ? row_y : f_max_y;
    m_q = (row_ok && q_rows != 12'hFFF) ? q_rows + 12'd1 : q_rows;
    frame_ok = m_q >= MIN_ROWS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
      row_cnt <= '0;
      row_min_x <= 12'hFFF;
      row_max_x <= '0;
      row_y <= '0;
      f_min_x <= 12'hFFF;
      f_max_x <= '0;
      f_min_y <= 12'hFFF;
      f_max_y <= '0;
      q_rows <= '0;
      edge_left <= '0;
      edge_right <= '0;
      edge_up <= '0;
      edge_dowm <= '0;
      region_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      de_d <= i_de;
      vs_d <= i_vs;
      frame_done <= frame_close;
      if (row_close) begin
        row_cnt <= '0;
        row_min_x <= 12'hFFF;
        row_max_x <= '0;
      end else if (hit) begin
        row_cnt <= (row_cnt != 12'hFFF) ? row_cnt + 12'd1 : row_cnt;
        row_min_x <= (x < row_min_x) ? x : row_min_x;
        row_max_x <= (x > row_max_x) ? x : row_max_x;
        row_y <= y;
      end
      if (frame_close) begin
        f_min_x <= 12'hFFF;
        f_max_x <= '0;
        f_min_y <= 12'hFFF;
        f_max_y <= '0;
        q_rows <= '0;
        region_valid <= frame_ok;
        if (frame_ok) begin
          edge_left <= m_min_x;
          edge_right <= m_max_x;
          edge_up <= m_min_y;
          edge_dowm <= m_max_y;
        end
      end else begin
        f_min_x <= m_min_x;
        f_max_x <= m_max_x;
        f_min_y <= m_min_y;
        f_max_y <= m_max_y;
        q_rows <= m_q;
      end
    end
  end
endmodule
